data_memory: RTL and testbench

//   Word-addressed 32-bit data RAM for the single-cycle processor datapath.
//   - One synchronous write port (committed on the clk rising edge).
//   - One asynchronous read port, so load data is valid in the same cycle
//     the address is presented.
//   - A synchronous clear sweep after reset zeroes every word before the

---
 rtl/data_memory.sv | 80 ++++++++
 tb/tb_data_memory.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Word-addressed data RAM: one synchronous write port, one asynchronous read port,
// and a post-reset clear sweep. Define MEM_BYPASS_EN to forward write data on a read/write collision.
module data_memory #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [31:0]       waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [31:0]       raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] widx;
  logic [ADDR_W-1:0] ridx;
  logic [DATA_W-1:0] mem [DEPTH];

  // Upper address bits alias onto the same words by design.
  assign widx = waddr[ADDR_W-1:0];
  assign ridx = raddr[ADDR_W-1:0];

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, waddr[31:ADDR_W], raddr[31:ADDR_W]};

  // NOTE: sequential state uses <= so every flop samples pre-edge values
  // regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) ptr <= ptr + 1'b1;
    end
  end

  always_comb begin
    // NOTE: default first, so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      CLEAR:   if (&ptr) state_next = READY;
      READY:   state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    busy  = (state == CLEAR);
    rdata = '0;
    if (!busy) begin
      rdata = mem[ridx];
`ifdef MEM_BYPASS_EN
      if (we && (ridx == widx)) rdata = wdata;
`endif
    end
  end

  // NOTE: the array has no reset term; the sweep zeroes it one word per cycle,
  // which keeps it mappable onto a plain RAM macro.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) mem[ptr] <= '0;
      else if (we)        mem[widx] <= wdata;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory; expected values are hand-computed.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] raddr = '0;
  logic [31:0] rdata;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  data_memory #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Counts cycles with busy high, bounded so a stuck busy cannot hang the run.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    pulse_reset();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_busy: got %b want 1", busy);
    end
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      raddr = $urandom;
      #1;
      vectors++;
      if (rdata !== 32'h0) begin
        miscompares++;
        $display("FAIL sweep_rdata: cycle %0d raddr %h got %h want 0", n, raddr, rdata);
      end
      step();
      n++;
    end
    vectors++;
    if (n !== 256) begin
      miscompares++;
      $display("FAIL sweep_length: got %0d cycles want 256", n);
    end
    for (int i = 0; i < 256; i += 51) begin
      raddr = i;
      #1;
      vectors++;
      if (rdata !== 32'h0) begin
        miscompares++;
        $display("FAIL post_sweep_zero: raddr %0d got %h want 0", i, rdata);
      end
    end
  endtask

  task automatic test_write_read();
    write_word(32'd5, 32'hDEADBEEF);
    raddr = 32'd5; #1;
    vectors++;
    if (rdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL read_5: got %h want deadbeef", rdata);
    end
    raddr = 32'd6; #1;
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL read_6: got %h want 0", rdata);
    end
  endtask

  task automatic test_alias();
    write_word(32'h0000_0103, 32'h12345678);
    raddr = 32'd3; #1;
    vectors++;
    if (rdata !== 32'h12345678) begin
      miscompares++;
      $display("FAIL alias_read_3: got %h want 12345678", rdata);
    end
    raddr = 32'hFFFF_FF03; #1;
    vectors++;
    if (rdata !== 32'h12345678) begin
      miscompares++;
      $display("FAIL alias_read_ff03: got %h want 12345678", rdata);
    end
    write_word(32'hFFFF_FFFF, 32'hA5A5_0001);
    raddr = 32'd255; #1;
    vectors++;
    if (rdata !== 32'hA5A5_0001) begin
      miscompares++;
      $display("FAIL top_word: got %h want a5a50001", rdata);
    end
  endtask

  task automatic test_collision();
    logic [31:0] before_exp;
`ifdef MEM_BYPASS_EN
    before_exp = 32'd2;
`else
    before_exp = 32'd1;
`endif
    write_word(32'd7, 32'd1);
    we = 1'b1; waddr = 32'd7; wdata = 32'd2; raddr = 32'd7;
    #1;
    vectors++;
    if (rdata !== before_exp) begin
      miscompares++;
      $display("FAIL collision_before: got %h want %h", rdata, before_exp);
    end
    step();
    we = 1'b0; #1;
    vectors++;
    if (rdata !== 32'd2) begin
      miscompares++;
      $display("FAIL collision_after: got %h want 2", rdata);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; waddr = 32'd10 + i; wdata = 32'hC0DE_0000 + i;
      step();
    end
    we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      raddr = 32'd10 + i; #1;
      vectors++;
      if (rdata !== 32'hC0DE_0000 + i) begin
        miscompares++;
        $display("FAIL b2b_read_%0d: got %h want %h", 10 + i, rdata, 32'hC0DE_0000 + i);
      end
    end
  endtask

  task automatic test_write_while_busy();
    int n;
    write_word(32'd1, 32'h1111_1111);
    pulse_reset();
    step(); step();
    // Cycle 3 of the sweep: word 9 not yet cleared.
    we = 1'b1; waddr = 32'd9; wdata = 32'hFF; raddr = 32'd9; #1;
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL busy_forced_zero: got %h want 0", rdata);
    end
    step();
    // Word 1 was already cleared, so a committed write would survive the sweep.
    waddr = 32'd1; wdata = 32'hFF;
    step();
    we = 1'b0;
    count_busy(n);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles", busy, n);
    end
    raddr = 32'd9; #1;
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL busy_write_9: got %h want 0", rdata);
    end
    raddr = 32'd1; #1;
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL busy_write_1: got %h want 0", rdata);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    write_word(32'd50, 32'hBBBB_BBBB);
    write_word(32'd200, 32'hAAAA_AAAA);
    pulse_reset();
    for (int i = 1; i < 100; i++) step();
    pulse_reset();
    count_busy(n);
    vectors++;
    if (n !== 256) begin
      miscompares++;
      $display("FAIL restart_length: got %0d cycles want 256", n);
    end
    for (int i = 0; i < 4; i++) begin
      raddr = (i == 0) ? 32'd0 : (i == 1) ? 32'd50 : (i == 2) ? 32'd200 : 32'd255;
      #1;
      vectors++;
      if (rdata !== 32'h0) begin
        miscompares++;
        $display("FAIL restart_zero: raddr %0d got %h want 0", raddr, rdata);
      end
    end
  endtask

  initial begin
    step();
    test_reset();
    test_write_read();
    test_alias();
    test_collision();
    test_back_to_back();
    test_write_while_busy();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
